// File: rtl/i2c_apb_pkg.sv
// Shared constants and types for the I2C-over-APB request sequencer.
package i2c_apb_pkg;

  // APB-to-I2C core register map
  localparam logic [7:0] REG_PRESCALE = 8'd2;
  localparam logic [7:0] REG_STATUS   = 8'd3;
  localparam logic [7:0] REG_CMD      = 8'd4;
  localparam logic [7:0] REG_RX_DATA  = 8'd5;
  localparam logic [7:0] REG_TX_DATA  = 8'd6;

  // CMD register bits
  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_STOP  = 8'h02;
  localparam logic [7:0] CMD_WRITE = 8'h04;
  localparam logic [7:0] CMD_READ  = 8'h08;

  // STATUS register bit positions
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_NACK = 1;

  // Client response codes
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_ADDR,
    ST_CMD_A,
    ST_POLL_A,
    ST_DATA,
    ST_CMD_D,
    ST_POLL_D,
    ST_RXRD,
    ST_STOP,
    ST_RESP
  } state_e;

  // Every state except IDLE and RESP performs exactly one APB access per visit
  function automatic logic is_access(state_e s);
    return !(s == ST_IDLE || s == ST_RESP);
  endfunction

endpackage

// File: rtl/i2c_apb_sequencer_if.sv
// Bus bundles: APB master/slave link and the client request/response link.
interface apb_if #(
  parameter int ADDR_W = 8
);
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [7:0]        PWDATA;
  logic [7:0]        PRDATA;
  logic              PREADY;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

interface i2c_req_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] prescale;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_err;

  // Sequencer side
  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, prescale,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

  // Client side
  modport master (
    output req_valid, req_rw, req_addr, req_wdata, prescale,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/apb_master_port.sv
// Single-outstanding APB master: idle -> SETUP -> ACCESS (+wait states) -> idle.
// A start request is taken only while idle; done_o fires on the completing ACCESS cycle.
module apb_master_port #(
  parameter int ADDR_W = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_if.master             apb,
  input  logic              start_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic              done_o,
  output logic [7:0]        rdata_o
);

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [7:0]        pwdata_q, pwdata_d;

  // Phase sequencing; address/control/data are captured at SETUP and held until done
  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    if (!psel_q) begin
      if (start_i) begin
        psel_d   = 1'b1;
        pwrite_d = wr_i;
        paddr_d  = addr_i;
        pwdata_d = wr_i ? wdata_i : 8'h00;
      end
    end else if (!penable_q) begin
      penable_d = 1'b1;
    end else if (apb.PREADY) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end
  end

  // Bus registers; reset drops PSELx/PENABLE immediately
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= 8'h00;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign apb.PSELx   = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;

  assign done_o  = psel_q & penable_q & apb.PREADY;
  assign rdata_o = apb.PRDATA;

endmodule

// File: rtl/i2c_apb_sequencer.sv
// Turns single-byte I2C client requests into the PRESCALE/TX/CMD/STATUS/RX
// register sequence of the APB-to-I2C core, with NACK and poll-timeout reporting.
module i2c_apb_sequencer
  import i2c_apb_pkg::*;
#(
  parameter int POLL_MAX = 255,
  parameter int ADDR_W   = 8
) (
  input  logic      PCLK,
  input  logic      PRESETn,
  i2c_req_if.slave  req,
  apb_if.master     apb
);

  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX + 1) : 1;

  state_e            state_q, state_d;
  logic              rw_q, rw_d;
  logic [6:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        pre_q, pre_d;
  logic [7:0]        last_pre_q, last_pre_d;
  logic              cfg_done_q, cfg_done_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        rx_q, rx_d;
  logic [PW-1:0]     poll_q, poll_d;

  logic              acc_start;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [7:0]        acc_wdata;
  logic              acc_done;
  logic [7:0]        acc_rdata;
  logic              st_busy;
  logic              st_nack;
  logic              poll_last;

  assign acc_start = is_access(state_q);
  assign st_busy   = acc_rdata[STATUS_BUSY];
  assign st_nack   = acc_rdata[STATUS_NACK];
  assign poll_last = (poll_q == PW'(POLL_MAX - 1));

  apb_master_port #(.ADDR_W(ADDR_W)) u_port (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (apb),
    .start_i (acc_start),
    .wr_i    (acc_wr),
    .addr_i  (acc_addr),
    .wdata_i (acc_wdata),
    .done_o  (acc_done),
    .rdata_o (acc_rdata)
  );

  // Sequencer next-state: each access state advances when its APB access completes
  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    pre_d      = pre_q;
    last_pre_d = last_pre_q;
    cfg_done_d = cfg_done_q;
    err_d      = err_q;
    rx_d       = rx_q;
    poll_d     = poll_q;
    acc_wr     = 1'b0;
    acc_addr   = '0;
    acc_wdata  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (req.req_valid) begin
          rw_d    = req.req_rw;
          addr_d  = req.req_addr;
          wdata_d = req.req_wdata;
          pre_d   = req.prescale;
          err_d   = ERR_OK;
          rx_d    = 8'h00;
          // Prescale is only reprogrammed when it actually changes
          if (!cfg_done_q || req.prescale != last_pre_q) state_d = ST_CFG;
          else                                           state_d = ST_ADDR;
        end
      end
      ST_CFG: begin
        acc_wr    = 1'b1;
        acc_addr  = ADDR_W'(REG_PRESCALE);
        acc_wdata = pre_q;
        if (acc_done) begin
          cfg_done_d = 1'b1;
          last_pre_d = pre_q;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        acc_wr    = 1'b1;
        acc_addr  = ADDR_W'(REG_TX_DATA);
        acc_wdata = {addr_q, rw_q};
        if (acc_done) state_d = ST_CMD_A;
      end
      ST_CMD_A: begin
        acc_wr    = 1'b1;
        acc_addr  = ADDR_W'(REG_CMD);
        acc_wdata = CMD_START | CMD_WRITE;
        if (acc_done) begin
          poll_d  = '0;
          state_d = ST_POLL_A;
        end
      end
      ST_POLL_A: begin
        acc_addr = ADDR_W'(REG_STATUS);
        if (acc_done) begin
          if (st_busy) begin
            if (poll_last) begin
              err_d   = ERR_TIMEOUT;
              state_d = ST_STOP;
            end else begin
              poll_d = poll_q + 1'b1;
            end
          end else if (st_nack) begin
            err_d   = ERR_NACK;
            state_d = ST_STOP;
          end else if (rw_q) begin
            state_d = ST_CMD_D;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        acc_wr    = 1'b1;
        acc_addr  = ADDR_W'(REG_TX_DATA);
        acc_wdata = wdata_q;
        if (acc_done) state_d = ST_CMD_D;
      end
      ST_CMD_D: begin
        acc_wr    = 1'b1;
        acc_addr  = ADDR_W'(REG_CMD);
        acc_wdata = rw_q ? (CMD_READ | CMD_STOP) : (CMD_WRITE | CMD_STOP);
        if (acc_done) begin
          poll_d  = '0;
          state_d = ST_POLL_D;
        end
      end
      ST_POLL_D: begin
        acc_addr = ADDR_W'(REG_STATUS);
        if (acc_done) begin
          if (st_busy) begin
            if (poll_last) begin
              err_d   = ERR_TIMEOUT;
              state_d = ST_STOP;
            end else begin
              poll_d = poll_q + 1'b1;
            end
          end else if (rw_q) begin
            state_d = ST_RXRD;
          end else begin
            // STOP already went out with the data command
            if (st_nack) err_d = ERR_NACK;
            state_d = ST_RESP;
          end
        end
      end
      ST_RXRD: begin
        acc_addr = ADDR_W'(REG_RX_DATA);
        if (acc_done) begin
          rx_d    = acc_rdata;
          state_d = ST_RESP;
        end
      end
      ST_STOP: begin
        acc_wr    = 1'b1;
        acc_addr  = ADDR_W'(REG_CMD);
        acc_wdata = CMD_STOP;
        if (acc_done) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state registers; reset forgets the programmed prescale
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      rw_q       <= 1'b0;
      addr_q     <= 7'h00;
      wdata_q    <= 8'h00;
      pre_q      <= 8'h00;
      last_pre_q <= 8'h00;
      cfg_done_q <= 1'b0;
      err_q      <= ERR_OK;
      rx_q       <= 8'h00;
      poll_q     <= '0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      pre_q      <= pre_d;
      last_pre_q <= last_pre_d;
      cfg_done_q <= cfg_done_d;
      err_q      <= err_d;
      rx_q       <= rx_d;
      poll_q     <= poll_d;
    end
  end

  // Ready is held low for the whole reset and rises as soon as it lifts
  assign req.req_ready = (state_q == ST_IDLE) & PRESETn;
  assign req.rsp_valid = (state_q == ST_RESP);
  assign req.rsp_data  = rx_q;
  assign req.rsp_err   = err_q;

endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// Directed bench for i2c_apb_sequencer with a behavioural APB-to-I2C core model.
module tb_i2c_apb_sequencer;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_if #(.ADDR_W(8)) apb ();
  i2c_req_if rq ();

  i2c_apb_sequencer #(.POLL_MAX(4), .ADDR_W(8)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .req     (rq),
    .apb     (apb)
  );

  // Core model knobs
  int         busy_left  = 0;   // STATUS reads still returning BUSY=1
  int         stall_left = 0;   // PREADY-low cycles to insert on the next CMD write
  logic       nack       = 1'b0;
  logic [7:0] rx_byte    = 8'h00;

  assign apb.PREADY = !(apb.PSELx && apb.PENABLE && apb.PWRITE &&
                        apb.PADDR == 8'd4 && stall_left > 0);
  assign apb.PRDATA = (apb.PADDR == 8'd3) ? {6'd0, nack, (busy_left > 0)} :
                      (apb.PADDR == 8'd5) ? rx_byte : 8'h00;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  acc_t log_q[$];
  acc_t exp_q[$];

  // Record each completed access and advance the model
  always @(posedge PCLK) begin
    if (PRESETn && apb.PSELx && apb.PENABLE) begin
      if (!apb.PREADY) begin
        stall_left <= stall_left - 1;
      end else begin
        log_q.push_back({apb.PWRITE, apb.PADDR, apb.PWRITE ? apb.PWDATA : apb.PRDATA});
        if (!apb.PWRITE && apb.PADDR == 8'd3 && busy_left > 0)
          busy_left <= busy_left - 1;
      end
    end
  end

  int   tests = 0;
  int   fails = 0;
  int   cyc_r;
  logic got_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ex(input logic wr, input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({wr, a, d});
  endtask

  task automatic clear_logs();
    log_q.delete();
    exp_q.delete();
  endtask

  // Issue one request, scramble the request fields after accept, wait for rsp_valid
  task automatic run_req(input logic rw, input logic [6:0] a, input logic [7:0] wd,
                         input logic [7:0] pre);
    int w;
    @(negedge PCLK);
    rq.req_valid = 1'b1;
    rq.req_rw    = rw;
    rq.req_addr  = a;
    rq.req_wdata = wd;
    rq.prescale  = pre;
    w = 0;
    while (!rq.req_ready && w < 50) begin
      @(negedge PCLK);
      w++;
    end
    @(posedge PCLK);
    @(negedge PCLK);
    rq.req_valid = 1'b0;
    rq.req_addr  = 7'h7F;
    rq.req_wdata = 8'hFF;
    rq.prescale  = 8'hEE;
    cyc_r = 1;
    while (!rq.rsp_valid && cyc_r < 200) begin
      @(negedge PCLK);
      cyc_r++;
    end
    got_r = rq.rsp_valid;
  endtask

  task automatic finish_txn(input string tag, input int exp_cyc, input logic [1:0] exp_err,
                            input logic [7:0] exp_data);
    chk({tag, "_rsp_seen"}, 32'(got_r), 32'd1);
    chk({tag, "_latency"}, 32'(cyc_r), 32'(exp_cyc));
    chk({tag, "_rsp_err"}, 32'(rq.rsp_err), 32'(exp_err));
    chk({tag, "_rsp_data"}, 32'(rq.rsp_data), 32'(exp_data));
    chk({tag, "_acc_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size())
        chk($sformatf("%s_acc%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    end
    $display("[TB] txn %s: rsp_err=%0d rsp_data=%02h latency=%0d accesses=%0d",
             tag, rq.rsp_err, rq.rsp_data, cyc_r, log_q.size());
    @(negedge PCLK);
    chk({tag, "_rsp_pulse"}, 32'(rq.rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rq.req_valid = 1'b0;
    rq.req_rw    = 1'b0;
    rq.req_addr  = 7'h00;
    rq.req_wdata = 8'h00;
    rq.prescale  = 8'h00;

    // Reset values
    repeat (3) @(negedge PCLK);
    chk("rst_req_ready", 32'(rq.req_ready), 32'd0);
    chk("rst_psel", 32'(apb.PSELx), 32'd0);
    chk("rst_paddr", 32'(apb.PADDR), 32'd0);
    chk("rst_rsp_valid", 32'(rq.rsp_valid), 32'd0);
    PRESETn = 1'b1;
    #1;
    chk("ready_after_rst", 32'(rq.req_ready), 32'd1);

    // First write: prescale programmed, one poll per phase
    clear_logs();
    ex(1'b1, 8'd2, 8'h10); ex(1'b1, 8'd6, 8'hA0); ex(1'b1, 8'd4, 8'h05); ex(1'b0, 8'd3, 8'h00);
    ex(1'b1, 8'd6, 8'hA5); ex(1'b1, 8'd4, 8'h06); ex(1'b0, 8'd3, 8'h00);
    run_req(1'b0, 7'h50, 8'hA5, 8'h10);
    finish_txn("wr_first", 22, 2'd0, 8'h00);

    // Second write, same prescale: fastest path
    clear_logs();
    ex(1'b1, 8'd6, 8'hA0); ex(1'b1, 8'd4, 8'h05); ex(1'b0, 8'd3, 8'h00);
    ex(1'b1, 8'd6, 8'h5A); ex(1'b1, 8'd4, 8'h06); ex(1'b0, 8'd3, 8'h00);
    run_req(1'b0, 7'h50, 8'h5A, 8'h10);
    finish_txn("wr_fast", 19, 2'd0, 8'h00);

    // Read
    clear_logs();
    rx_byte = 8'h3C;
    ex(1'b1, 8'd6, 8'hA1); ex(1'b1, 8'd4, 8'h05); ex(1'b0, 8'd3, 8'h00);
    ex(1'b1, 8'd4, 8'h0A); ex(1'b0, 8'd3, 8'h00); ex(1'b0, 8'd5, 8'h3C);
    run_req(1'b1, 7'h50, 8'h00, 8'h10);
    finish_txn("rd", 19, 2'd0, 8'h3C);

    // Address NACK
    clear_logs();
    nack = 1'b1;
    ex(1'b1, 8'd6, 8'h44); ex(1'b1, 8'd4, 8'h05); ex(1'b0, 8'd3, 8'h02); ex(1'b1, 8'd4, 8'h02);
    run_req(1'b0, 7'h22, 8'h11, 8'h10);
    finish_txn("nack", 13, 2'd1, 8'h00);
    nack = 1'b0;

    // BUSY stuck: POLL_MAX reads then STOP; new prescale forces CFG
    clear_logs();
    busy_left = 1000;
    ex(1'b1, 8'd2, 8'h20); ex(1'b1, 8'd6, 8'h23); ex(1'b1, 8'd4, 8'h05);
    for (int i = 0; i < 4; i++) ex(1'b0, 8'd3, 8'h01);
    ex(1'b1, 8'd4, 8'h02);
    run_req(1'b1, 7'h11, 8'h00, 8'h20);
    finish_txn("timeout", 25, 2'd2, 8'h00);
    busy_left = 0;

    // Wait states on the CMD access, then reset mid-poll
    clear_logs();
    busy_left  = 1000;
    stall_left = 3;
    @(negedge PCLK);
    rq.req_valid = 1'b1;
    rq.req_rw    = 1'b0;
    rq.req_addr  = 7'h50;
    rq.req_wdata = 8'h77;
    rq.prescale  = 8'h20;
    @(posedge PCLK);
    @(negedge PCLK);
    rq.req_valid = 1'b0;
    w = 0;
    while (!(apb.PSELx && apb.PENABLE && apb.PADDR == 8'd4) && w < 40) begin
      @(negedge PCLK);
      w++;
    end
    chk("stall_reached", 32'(apb.PSELx && apb.PENABLE && apb.PADDR == 8'd4), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_pready", k), 32'(apb.PREADY), 32'd0);
      chk($sformatf("stall%0d_penable", k), 32'(apb.PENABLE), 32'd1);
      chk($sformatf("stall%0d_paddr", k), 32'(apb.PADDR), 32'd4);
      chk($sformatf("stall%0d_pwdata", k), 32'(apb.PWDATA), 32'h05);
      chk($sformatf("stall%0d_pwrite", k), 32'(apb.PWRITE), 32'd1);
      @(negedge PCLK);
    end
    chk("stall_release_pready", 32'(apb.PREADY), 32'd1);
    chk("stall_release_penable", 32'(apb.PENABLE), 32'd1);
    w = 0;
    while (!(apb.PSELx && apb.PADDR == 8'd3) && w < 40) begin
      @(negedge PCLK);
      w++;
    end
    chk("poll_reached", 32'(apb.PSELx && apb.PADDR == 8'd3), 32'd1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("async_rst_psel", 32'(apb.PSELx), 32'd0);
    chk("async_rst_penable", 32'(apb.PENABLE), 32'd0);
    chk("async_rst_paddr", 32'(apb.PADDR), 32'd0);
    chk("async_rst_pwrite", 32'(apb.PWRITE), 32'd0);
    chk("async_rst_req_ready", 32'(rq.req_ready), 32'd0);
    chk("async_rst_rsp", 32'({rq.rsp_valid, rq.rsp_err, rq.rsp_data}), 32'd0);
    $display("[TB] txn stall_reset: aborted mid-poll after %0d accesses", log_q.size());
    repeat (2) @(negedge PCLK);
    busy_left  = 0;
    stall_left = 0;
    PRESETn    = 1'b1;

    // After reset the same prescale must be programmed again
    clear_logs();
    ex(1'b1, 8'd2, 8'h20); ex(1'b1, 8'd6, 8'hA0); ex(1'b1, 8'd4, 8'h05); ex(1'b0, 8'd3, 8'h00);
    ex(1'b1, 8'd6, 8'h77); ex(1'b1, 8'd4, 8'h06); ex(1'b0, 8'd3, 8'h00);
    run_req(1'b0, 7'h50, 8'h77, 8'h20);
    finish_txn("post_rst", 22, 2'd0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
